// File: rtl/cluster_dma_pkg.sv
// Shared types for the cluster DMA retire tracking logic.
// IDs are stored at the widest legal width so one entry type serves every IdWidth.
package cluster_dma_pkg;

  localparam int MaxIdWidth = 32;

  typedef struct packed {
    logic [MaxIdWidth-1:0] id;
    logic                  done;
  } entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cluster_dma_id_cam.sv
// Associative ID lookup across all live tracker entries.
// Produces a one-hot hit vector plus a flag when more than one entry hits.
module cluster_dma_id_cam
  import cluster_dma_pkg::*;
#(
  parameter int NumEntries = 8
) (
  input  logic [NumEntries-1:0] valid,
  input  logic [MaxIdWidth-1:0] ids [NumEntries],
  input  logic [MaxIdWidth-1:0] key,
  output logic [NumEntries-1:0] match,
  output logic                  multi
);

  always_comb begin
    match = '0;
    for (int i = 0; i < NumEntries; i++) begin
      match[i] = valid[i] && (ids[i] == key);
    end
  end

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign multi = |(match & (match - NumEntries'(1)));

endmodule

// File: rtl/cluster_dma_retire_reorder.sv
// Tracks in-flight DMA transfers and retires them strictly in issue order,
// regardless of the order in which the backend reports completion.
module cluster_dma_retire_reorder
  import cluster_dma_pkg::*;
#(
  parameter int IdWidth        = 16,
  parameter int NumOutstanding = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   issue_valid_i,
  input  logic [IdWidth-1:0]                     issue_id_i,
  output logic                                   issue_ready_o,
  input  logic                                   done_valid_i,
  input  logic [IdWidth-1:0]                     done_id_i,
  output logic                                   retire_o,
  output logic [IdWidth-1:0]                     retired_id_o,
  output logic [count_width(NumOutstanding)-1:0] outstanding_o,
  output logic                                   err_o
);

  localparam int PtrWidth = $clog2(NumOutstanding);
  localparam int CntWidth = count_width(NumOutstanding);

  entry_t                      entries [NumOutstanding];
  logic [NumOutstanding-1:0]   valid;
  logic [PtrWidth-1:0]         head;
  logic [PtrWidth-1:0]         tail;
  logic [CntWidth-1:0]         count;
  logic                        err;

  logic [MaxIdWidth-1:0]       ids [NumOutstanding];
  logic [NumOutstanding-1:0]   done_vec;
  logic [NumOutstanding-1:0]   match;
  logic                        multi;

  logic issue_err;
  logic issue_accept;
  logic done_err;
  logic done_set;

  always_comb begin
    for (int i = 0; i < NumOutstanding; i++) begin
      ids[i]      = entries[i].id;
      done_vec[i] = entries[i].done;
    end
  end

  // The slot being written is never valid yet, so a same-cycle done for it misses.
  cluster_dma_id_cam #(
    .NumEntries(NumOutstanding)
  ) u_cam (
    .valid(valid),
    .ids  (ids),
    .key  (MaxIdWidth'(done_id_i)),
    .match(match),
    .multi(multi)
  );

  assign issue_ready_o = (count < CntWidth'(NumOutstanding));
  assign issue_err     = issue_valid_i && (!issue_ready_o || (issue_id_i == '0));
  assign issue_accept  = issue_valid_i && !issue_err;

  assign done_err = done_valid_i && ((match == '0) || multi || (|(match & done_vec)));
  assign done_set = done_valid_i && !done_err;

  assign retire_o      = valid[head] && entries[head].done;
  assign retired_id_o  = retire_o ? entries[head].id[IdWidth-1:0] : '0;
  assign outstanding_o = count;
  assign err_o         = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      err   <= 1'b0;
      for (int i = 0; i < NumOutstanding; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (issue_err || done_err) begin
        err <= 1'b1;
      end

      // Pop, push and done-marking never target the same slot in one cycle.
      for (int i = 0; i < NumOutstanding; i++) begin
        if (retire_o && (head == PtrWidth'(i))) begin
          valid[i]        <= 1'b0;
          entries[i].done <= 1'b0;
        end
        if (issue_accept && (tail == PtrWidth'(i))) begin
          valid[i]   <= 1'b1;
          entries[i] <= '{id: MaxIdWidth'(issue_id_i), done: 1'b0};
        end
        if (done_set && match[i]) begin
          entries[i].done <= 1'b1;
        end
      end

      if (retire_o) begin
        head <= head + PtrWidth'(1);
      end
      if (issue_accept) begin
        tail <= tail + PtrWidth'(1);
      end

      case ({issue_accept, retire_o})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_dma_retire_reorder.sv
// Randomized and directed bench for the in-order DMA retire tracker,
// compared every cycle against a queue-based reference model.
module tb_cluster_dma_retire_reorder;

  localparam int IdWidth        = 4;
  localparam int NumOutstanding = 4;
  localparam int CntWidth       = $clog2(NumOutstanding + 1);

  logic                clk_i;
  logic                rst_i;
  logic                issue_valid_i;
  logic [IdWidth-1:0]  issue_id_i;
  logic                issue_ready_o;
  logic                done_valid_i;
  logic [IdWidth-1:0]  done_id_i;
  logic                retire_o;
  logic [IdWidth-1:0]  retired_id_o;
  logic [CntWidth-1:0] outstanding_o;
  logic                err_o;

  cluster_dma_retire_reorder #(
    .IdWidth       (IdWidth),
    .NumOutstanding(NumOutstanding)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .issue_valid_i(issue_valid_i),
    .issue_id_i   (issue_id_i),
    .issue_ready_o(issue_ready_o),
    .done_valid_i (done_valid_i),
    .done_id_i    (done_id_i),
    .retire_o     (retire_o),
    .retired_id_o (retired_id_o),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: a FIFO of issued transfers in issue order plus a sticky error.
  typedef struct {
    logic [IdWidth-1:0] id;
    bit                 done;
  } ment_t;

  ment_t q[$];
  bit    mErr;
  int    checks;
  int    errors;
  logic [IdWidth-1:0] nextId;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkState();
    bit expRetire;
    expRetire = (q.size() > 0) && q[0].done;
    checkOutput("ready", 32'(issue_ready_o), 32'(q.size() < NumOutstanding));
    checkOutput("retire", 32'(retire_o), 32'(expRetire));
    checkOutput("retired_id", 32'(retired_id_o), expRetire ? 32'(q[0].id) : 32'd0);
    checkOutput("outstanding", 32'(outstanding_o), 32'(q.size()));
    checkOutput("err", 32'(err_o), 32'(mErr));
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance the model.
  task automatic applyStimulus(input bit iv, input logic [IdWidth-1:0] iid,
                               input bit dv, input logic [IdWidth-1:0] did);
    bit retiring;
    bit issueOk;
    bit e;
    int hits;
    int k;
    checkState();
    issue_valid_i = iv;
    issue_id_i    = iid;
    done_valid_i  = dv;
    done_id_i     = did;

    retiring = (q.size() > 0) && q[0].done;
    issueOk  = iv && (q.size() < NumOutstanding) && (iid != 0);
    e        = iv && !issueOk;
    if (dv) begin
      hits = 0;
      k    = -1;
      foreach (q[j]) if (q[j].id == did) begin hits++; k = j; end
      if (hits != 1) e = 1'b1;
      else if (q[k].done) e = 1'b1;
      else q[k].done = 1'b1;
    end
    if (retiring) void'(q.pop_front());
    if (issueOk) q.push_back('{id: iid, done: 1'b0});
    if (e) mErr = 1'b1;

    @(posedge clk_i);
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    done_valid_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0);
  endtask

  // Reset asserted mid-cycle, away from the clock edge; outputs checked while held.
  task automatic doReset();
    #2 rst_i = 1'b1;
    #1;
    q.delete();
    mErr = 1'b0;
    checkState();
    @(negedge clk_i);
    checkState();
    rst_i = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    mErr          = 1'b0;
    rst_i         = 1'b0;
    issue_valid_i = 1'b0;
    issue_id_i    = '0;
    done_valid_i  = 1'b0;
    done_id_i     = '0;
    @(negedge clk_i);
    doReset();

    $display("[TB] head completes first");
    applyStimulus(1, 4'd2, 0, '0);
    applyStimulus(1, 4'd3, 0, '0);
    applyStimulus(1, 4'd4, 0, '0);
    applyStimulus(0, '0, 1, 4'd2);
    idle(2);

    $display("[TB] reverse completion order");
    doReset();
    applyStimulus(1, 4'd2, 0, '0);
    applyStimulus(1, 4'd3, 0, '0);
    applyStimulus(1, 4'd4, 0, '0);
    applyStimulus(0, '0, 1, 4'd4);
    applyStimulus(0, '0, 1, 4'd3);
    idle(1);
    applyStimulus(0, '0, 1, 4'd2);
    idle(4);

    $display("[TB] full tracker and overflow issue");
    doReset();
    applyStimulus(1, 4'd1, 0, '0);
    applyStimulus(1, 4'd2, 0, '0);
    applyStimulus(1, 4'd3, 0, '0);
    applyStimulus(1, 4'd4, 0, '0);
    applyStimulus(1, 4'd5, 0, '0);
    applyStimulus(0, '0, 1, 4'd1);
    idle(3);

    $display("[TB] ID wrap with scrambled completion");
    doReset();
    applyStimulus(1, 4'd14, 0, '0);
    applyStimulus(1, 4'd15, 0, '0);
    applyStimulus(1, 4'd1, 0, '0);
    applyStimulus(1, 4'd2, 0, '0);
    applyStimulus(0, '0, 1, 4'd1);
    applyStimulus(0, '0, 1, 4'd15);
    applyStimulus(0, '0, 1, 4'd14);
    applyStimulus(0, '0, 1, 4'd2);
    idle(5);

    $display("[TB] protocol errors");
    doReset();
    applyStimulus(0, '0, 1, 4'd9);
    idle(1);
    applyStimulus(1, 4'd2, 1, 4'd2);
    applyStimulus(1, 4'd3, 0, '0);
    applyStimulus(0, '0, 1, 4'd3);
    applyStimulus(0, '0, 1, 4'd3);
    applyStimulus(1, 4'd0, 0, '0);
    idle(3);

    $display("[TB] concurrent issue/done/retire then mid-stream reset");
    doReset();
    applyStimulus(1, 4'd1, 0, '0);
    applyStimulus(1, 4'd2, 0, '0);
    applyStimulus(1, 4'd3, 0, '0);
    applyStimulus(1, 4'd4, 1, 4'd1);
    applyStimulus(0, '0, 0, '0);
    applyStimulus(1, 4'd5, 1, 4'd2);
    applyStimulus(1, 4'd6, 1, 4'd3);
    doReset();
    idle(3);

    $display("[TB] randomized traffic");
    for (int r = 0; r < 4; r++) begin
      doReset();
      nextId = 4'd1;
      for (int c = 0; c < 150; c++) begin
        bit iv;
        bit dv;
        logic [IdWidth-1:0] iid;
        logic [IdWidth-1:0] did;
        int pend[$];
        iv = ($urandom % 3) != 0;
        if (q.size() >= NumOutstanding && ($urandom % 20) != 0) iv = 1'b0;
        iid = nextId;
        if (iv && q.size() < NumOutstanding) nextId = (nextId == 4'd15) ? 4'd1 : nextId + 4'd1;
        pend.delete();
        foreach (q[j]) if (!q[j].done) pend.push_back(j);
        dv  = (pend.size() > 0) && (($urandom % 5) < 3);
        did = dv ? q[pend[$urandom_range(0, pend.size() - 1)]].id : '0;
        if (($urandom % 40) == 0) begin
          dv  = 1'b1;
          did = ($urandom % 2) ? iid : IdWidth'($urandom);
        end
        applyStimulus(iv, iid, dv, did);
      end
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
